mask_stream_rx: RTL and testbench
=================================

// Module: mask_stream_rx
// PURPOSE
//  Receive side of the 3-channel contrast stream ([23:16] saturation, [15:8] mask/contrasted, [7:0] original).
//  Composes one 8-bit display pixel per beat and buffers it in a FIFO toward a back-pressured AXI-Stream sink.
//  Checks SOF/EOL framing against the configured geometry and reports per-frame mask/saturation pixel counts.
// PARAMETERS
//  DATA_WIDTH  8    channel width; input is 3*DATA_WIDTH
//  IMG_WIDTH   640  pixels per line
//  IMG_HEIGHT  480  lines per frame
//  FIFO_DEPTH  16   output FIFO entries, power of 2, >=2
//  CNT_WIDTH   20   per-frame counter width
// PORTS
//  i_sys_clk          in   1     clock
//  i_sys_aresetn      in   1     async active-low reset
//  overlay_mode       in   2     0 orig, 1 mask chan, 2 overlay, 3 sat-blank
//  mask_color         in   DW    overlay colour for mask pixels
//  clear_errors       in   1     clears sticky error flags
//  s_axis_tdata       in   3*DW  {sat, mask, orig}
//  s_axis_tvalid      in   1     input beat valid
//  s_axis_tuser       in   1     start of frame
//  s_axis_tlast       in   1     end of line
//  s_axis_tready      out  1     always-accept indication
//  m_axis_tdata       out  DW    composed pixel
//  m_axis_tvalid      out  1     output valid
//  m_axis_tuser       out  1     SOF, forwarded
//  m_axis_tlast       out  1     EOL, forwarded
//  m_axis_tready      in   1     sink ready
//  frame_mask_cnt     out  CW    mask pixels in last complete frame
//  frame_sat_cnt      out  CW    saturated pixels in last complete frame
//  frame_stats_valid  out  1     1-cycle pulse when counts update
//  err_sof            out  1     sticky: tuser inside unfinished frame
//  err_eol_early      out  1     sticky: tlast before IMG_WIDTH-th pixel
//  err_eol_late       out  1     sticky: IMG_WIDTH-th pixel without tlast
//  fifo_overflow      out  1     sticky: beat dropped, FIFO full
// BEHAVIOUR
//  Clock i_sys_clk; reset i_sys_aresetn, asynchronous, active-low; reset clears FIFO, counters, FSM, and every output to 0.
//  s_axis_tready: 0 in reset, 1 from the first edge after release. Upstream cannot stall; every valid beat is accepted.
//  Classification: mask_hit = (tdata[15:8] == all-ones); sat_hit = (tdata[23:16] != 0).
//  Composition, registered at acceptance edge k:
//   mode0 orig; mode1 tdata[15:8]; mode2 sat_hit ? all-ones : (mask_hit ? mask_color : orig); mode3 sat_hit ? 0 : orig.
//  Edge k+1 writes {tuser, tlast, pixel} into the FIFO. m_axis_tvalid = FIFO not empty (first-word fall-through).
//   Latency is 2 edges when the FIFO is empty.
//  Output obeys AXI-S: data/user/last stable while tvalid & !tready. Pop on tvalid & tready.
//  Full FIFO:
//   write with simultaneous pop succeeds;
//   write without pop drops the beat and sets fifo_overflow; no other state is corrupted.
//  FSM on accepted beats, states WAIT_SOF and IN_FRAME:
//   WAIT_SOF: non-tuser beats pass to the output but are not counted or checked. tuser -> IN_FRAME, pix=1, line=0, accum = this beat.
//   IN_FRAME: tuser -> err_sof=1, restart the frame as above. Otherwise pix++ and accumulate mask_hit/sat_hit.
//   Accumulators saturate at all-ones.
//   Beat at pix==IMG_WIDTH-1 without tlast -> err_eol_late, pix continues.
//   tlast with pix!=IMG_WIDTH-1 -> err_eol_early.
//   tlast -> pix=0, line++.
//   tlast on line IMG_HEIGHT-1 -> frame complete: frame_*_cnt <= accum incl. this beat, frame_stats_valid=1 next cycle, -> WAIT_SOF.
//   A one-pixel frame (tuser & tlast, H=1, W=1) both starts and completes.
//  Error flags are sticky. clear_errors clears them; a set in the same cycle wins over the clear.
//  frame_*_cnt hold their values until the next complete frame and are never updated by an aborted frame.
// TESTING
//  W=4,H=2,D=4, mode2, mask_color=8'h80: frame of 8 beats, beat1 mask=FF, beat2 sat=FF, tready=1
//   -> out 2 edges later: orig, 80, FF, orig...; tuser on beat0, tlast on beats 3,7;
//   -> frame_mask_cnt=1, frame_sat_cnt=1, one stats_valid pulse.
//  Same frame with tready=0 -> FIFO holds 4 entries, fifo_overflow=1 on the 5th beat;
//   -> release tready -> the 4 stored beats drain in order, data stable while stalled.
//  tlast on the 3rd pixel of line 0 -> err_eol_early=1.
//   4th pixel of a line without tlast -> err_eol_late=1.
//   clear_errors -> both 0.
//  New tuser after 5 beats of a frame -> err_sof=1; counts from the aborted frame never appear.
//   The following full frame reports correct counts.
//  Beats before the first tuser -> forwarded to output, no stats_valid, no errors.
//   Reset mid-frame -> all outputs 0, FIFO empty.
//  Modes 0/1/3 on input {FF,FF,42} -> 42 / FF / 00; input {00,FF,42} in mode3 -> 42.

Source files
------------

// File: rtl/mask_stream_rx.sv
// Receive side of the 3-channel contrast stream: composes a display pixel per beat,
// buffers it toward a back-pressured AXI-Stream sink, checks frame geometry and
// reports per-frame mask/saturation pixel counts.
module mask_stream_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 20
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_aresetn,
  input  logic [1:0]                overlay_mode,
  input  logic [DATA_WIDTH-1:0]     mask_color,
  input  logic                      clear_errors,
  input  logic [3*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tuser,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [CNT_WIDTH-1:0]      frame_mask_cnt,
  output logic [CNT_WIDTH-1:0]      frame_sat_cnt,
  output logic                      frame_stats_valid,
  output logic                      err_sof,
  output logic                      err_eol_early,
  output logic                      err_eol_late,
  output logic                      fifo_overflow
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned AW     = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PIX_W  = $clog2(IMG_WIDTH) + 1;
  localparam int unsigned LINE_W = $clog2(IMG_HEIGHT) + 1;
  localparam int unsigned ENT_W  = DW + 2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [PIX_W-1:0]     PIX_LAST  = PIX_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0]    LINE_LAST = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [AW:0]          FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {WAIT_SOF = 1'b0, IN_FRAME = 1'b1} state_t;

  logic              accept;
  logic              mask_hit;
  logic              sat_hit;
  logic [DW-1:0]     orig;
  logic [DW-1:0]     mask_ch;
  logic [DW-1:0]     pix_c;

  logic              stg_valid;
  logic [ENT_W-1:0]  stg_entry;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              drop;

  state_t            state;
  logic [PIX_W-1:0]  pix_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic [CNT_WIDTH-1:0] acc_mask;
  logic [CNT_WIDTH-1:0] acc_sat;

  logic [PIX_W-1:0]  cur_pix;
  logic [LINE_W-1:0] cur_line;
  logic [CNT_WIDTH-1:0] base_mask;
  logic [CNT_WIDTH-1:0] base_sat;
  logic [CNT_WIDTH-1:0] acc_mask_nxt;
  logic [CNT_WIDTH-1:0] acc_sat_nxt;
  logic              last_pix;
  logic              last_line;
  logic              frame_beat;
  logic              set_sof;
  logic              set_early;
  logic              set_late;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign orig     = s_axis_tdata[DW-1:0];
  assign mask_ch  = s_axis_tdata[2*DW-1:DW];
  assign mask_hit = &mask_ch;
  assign sat_hit  = |s_axis_tdata[3*DW-1:2*DW];

  // Pixel composition for the selected overlay mode.
  always_comb begin
    pix_c = orig;
    case (overlay_mode)
      2'd0:    pix_c = orig;
      2'd1:    pix_c = mask_ch;
      2'd2:    pix_c = sat_hit ? {DW{1'b1}} : (mask_hit ? mask_color : orig);
      default: pix_c = sat_hit ? '0 : orig;
    endcase
  end

  // Ready rises on the first edge after reset release; upstream is never stalled.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) s_axis_tready <= 1'b0;
    else                s_axis_tready <= 1'b1;
  end

  // Composition stage: registered at the acceptance edge.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      stg_valid <= 1'b0;
      stg_entry <= '0;
    end else begin
      stg_valid <= accept;
      if (accept) stg_entry <= {s_axis_tuser, s_axis_tlast, pix_c};
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_FULL);
  assign pop        = ~fifo_empty & m_axis_tready;
  assign push       = stg_valid & (~fifo_full | pop);
  assign drop       = stg_valid & fifo_full & ~pop;

  // FIFO storage, cleared on reset so the idle output reads zero.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= stg_entry;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign m_axis_tvalid = ~fifo_empty;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = mem[rd_ptr];

  // Frame position and accumulators as seen by the current beat (tuser restarts).
  always_comb begin
    cur_pix   = pix_cnt;
    cur_line  = line_cnt;
    base_mask = acc_mask;
    base_sat  = acc_sat;
    if (s_axis_tuser) begin
      cur_pix   = '0;
      cur_line  = '0;
      base_mask = '0;
      base_sat  = '0;
    end
    acc_mask_nxt = (base_mask == CNT_MAX) ? base_mask : base_mask + CNT_WIDTH'(mask_hit);
    acc_sat_nxt  = (base_sat  == CNT_MAX) ? base_sat  : base_sat  + CNT_WIDTH'(sat_hit);
    last_pix   = (cur_pix == PIX_LAST);
    last_line  = (cur_line == LINE_LAST);
    frame_beat = accept & (s_axis_tuser | (state == IN_FRAME));
    set_sof    = accept & s_axis_tuser & (state == IN_FRAME);
    set_early  = frame_beat & s_axis_tlast & ~last_pix;
    set_late   = frame_beat & ~s_axis_tlast & last_pix;
  end

  // Framing FSM, per-frame statistics and sticky error flags.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      state             <= WAIT_SOF;
      pix_cnt           <= '0;
      line_cnt          <= '0;
      acc_mask          <= '0;
      acc_sat           <= '0;
      frame_mask_cnt    <= '0;
      frame_sat_cnt     <= '0;
      frame_stats_valid <= 1'b0;
      err_sof           <= 1'b0;
      err_eol_early     <= 1'b0;
      err_eol_late      <= 1'b0;
      fifo_overflow     <= 1'b0;
    end else begin
      frame_stats_valid <= 1'b0;
      if (frame_beat) begin
        state    <= IN_FRAME;
        acc_mask <= acc_mask_nxt;
        acc_sat  <= acc_sat_nxt;
        if (s_axis_tlast) begin
          pix_cnt <= '0;
          if (last_line) begin
            frame_mask_cnt    <= acc_mask_nxt;
            frame_sat_cnt     <= acc_sat_nxt;
            frame_stats_valid <= 1'b1;
            line_cnt          <= '0;
            state             <= WAIT_SOF;
          end else begin
            line_cnt <= cur_line + LINE_W'(1);
          end
        end else begin
          pix_cnt  <= cur_pix + PIX_W'(1);
          line_cnt <= cur_line;
        end
      end
      err_sof       <= (err_sof       & ~clear_errors) | set_sof;
      err_eol_early <= (err_eol_early & ~clear_errors) | set_early;
      err_eol_late  <= (err_eol_late  & ~clear_errors) | set_late;
      fifo_overflow <= (fifo_overflow & ~clear_errors) | drop;
    end
  end

endmodule

// File: tb/tb_mask_stream_rx.sv
// Directed bench for mask_stream_rx with a small 4x2 geometry and a 4-entry FIFO.
module tb_mask_stream_rx;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 20;

  logic            clk;
  logic            rst_n;
  logic [1:0]      overlay_mode;
  logic [DW-1:0]   mask_color;
  logic            clear_errors;
  logic [3*DW-1:0] s_tdata;
  logic            s_tvalid;
  logic            s_tuser;
  logic            s_tlast;
  logic            s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tuser;
  logic            m_tlast;
  logic            m_tready;
  logic [CW-1:0]   frame_mask_cnt;
  logic [CW-1:0]   frame_sat_cnt;
  logic            frame_stats_valid;
  logic            err_sof;
  logic            err_eol_early;
  logic            err_eol_late;
  logic            fifo_overflow;

  mask_stream_rx #(
    .DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(2), .FIFO_DEPTH(4), .CNT_WIDTH(CW)
  ) dut (
    .i_sys_clk(clk),
    .i_sys_aresetn(rst_n),
    .overlay_mode(overlay_mode),
    .mask_color(mask_color),
    .clear_errors(clear_errors),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .frame_mask_cnt(frame_mask_cnt),
    .frame_sat_cnt(frame_sat_cnt),
    .frame_stats_valid(frame_stats_valid),
    .err_sof(err_sof),
    .err_eol_early(err_eol_early),
    .err_eol_late(err_eol_late),
    .fifo_overflow(fifo_overflow)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] data;
    logic        last;
    logic [7:0]  exp;
  } vec_t;

  vec_t       vecs [8];
  logic [9:0] exp_q [$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         pulses   = 0;
  logic [9:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] mode, input logic [7:0] mc,
                                       input logic [23:0] d);
    logic [7:0] sat, msk, org;
    sat = d[23:16];
    msk = d[15:8];
    org = d[7:0];
    case (mode)
      2'd0: return org;
      2'd1: return msk;
      2'd2: begin
        if (sat != 8'h00) return 8'hFF;
        if (msk == 8'hFF) return mc;
        return org;
      end
      default: return (sat != 8'h00) ? 8'h00 : org;
    endcase
  endfunction

  // Scoreboard: every handshake must match the next expected beat in order.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {22'd0, m_tuser, m_tlast, m_tdata}, 32'hFFFF_FFFF);
      end else begin
        chk("out_beat", {22'd0, m_tuser, m_tlast, m_tdata}, {22'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) if (frame_stats_valid) pulses++;

  task automatic beat(input logic [23:0] d, input logic u, input logic l);
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send(input logic [23:0] d, input logic u, input logic l, input logic push);
    if (push) exp_q.push_back({u, l, model(overlay_mode, mask_color, d)});
    beat(d, u, l);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_tvalid) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_timeout", 32'(k >= 60), 32'd0);
    chk("drain_leftover", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(posedge clk); #1;
    clear_errors = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd0, 24'hFFFF42, 1'b0, 8'h42};
    vecs[1] = '{2'd1, 24'hFFFF42, 1'b0, 8'hFF};
    vecs[2] = '{2'd3, 24'hFFFF42, 1'b1, 8'h00};
    vecs[3] = '{2'd3, 24'h00FF42, 1'b0, 8'h42};
    vecs[4] = '{2'd2, 24'h00FF42, 1'b0, 8'h80};
    vecs[5] = '{2'd2, 24'h01FF42, 1'b1, 8'hFF};
    vecs[6] = '{2'd2, 24'h007F42, 1'b0, 8'h42};
    vecs[7] = '{2'd1, 24'h005A42, 1'b0, 8'h5A};

    rst_n = 1'b0; overlay_mode = 2'd0; mask_color = 8'h80; clear_errors = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;

    // Reset state
    #12;
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_mdata", 32'(m_tdata), 32'd0);
    chk("rst_errs", {28'd0, err_sof, err_eol_early, err_eol_late, fifo_overflow}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("tready_after_rst", 32'(s_tready), 32'd1);

    // Latency on an empty FIFO, then the mode table (all before any tuser)
    overlay_mode = vecs[0].mode;
    exp_q.push_back({1'b0, vecs[0].last, vecs[0].exp});
    beat(vecs[0].data, 1'b0, vecs[0].last);
    chk("lat_edge1_valid", 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", 32'(m_tvalid), 32'd1);
    chk("lat_edge2_data", 32'(m_tdata), 32'h42);
    for (int i = 1; i < 8; i++) begin
      overlay_mode = vecs[i].mode;
      exp_q.push_back({1'b0, vecs[i].last, vecs[i].exp});
      beat(vecs[i].data, 1'b0, vecs[i].last);
    end
    drain();
    chk("presof_errs", {28'd0, err_sof, err_eol_early, err_eol_late, fifo_overflow}, 32'd0);
    chk("presof_pulses", 32'(pulses), 32'd0);

    // Full frame in overlay mode, sink always ready
    overlay_mode = 2'd2;
    for (int i = 0; i < 8; i++) begin
      send({(i == 2) ? 8'hFF : 8'h00, (i == 1) ? 8'hFF : 8'h00, 8'(8'h10 + i)},
           i == 0, (i == 3) || (i == 7), 1'b1);
    end
    idle(1);
    drain();
    chk("f1_mask_cnt", 32'(frame_mask_cnt), 32'd1);
    chk("f1_sat_cnt", 32'(frame_sat_cnt), 32'd1);
    chk("f1_pulses", 32'(pulses), 32'd1);
    chk("f1_errs", {28'd0, err_sof, err_eol_early, err_eol_late, fifo_overflow}, 32'd0);

    // Same frame with the sink stalled: four stored, the rest dropped
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send({(i == 2) ? 8'hFF : 8'h00, (i == 1) ? 8'hFF : 8'h00, 8'(8'h10 + i)},
           i == 0, (i == 3) || (i == 7), i < 4);
      if (i == 4) chk("ovf_before_5th", 32'(fifo_overflow), 32'd0);
      if (i == 5) chk("ovf_on_5th", 32'(fifo_overflow), 32'd1);
    end
    idle(2);
    held = {m_tuser, m_tlast, m_tdata};
    chk("stall_valid", 32'(m_tvalid), 32'd1);
    chk("stall_head", 32'(held), {22'd0, 1'b1, 1'b0, 8'h10});
    idle(3);
    chk("stall_stable", {22'd0, m_tuser, m_tlast, m_tdata}, 32'(held));
    chk("f2_pulses", 32'(pulses), 32'd2);
    chk("f2_mask_cnt", 32'(frame_mask_cnt), 32'd1);
    m_tready = 1'b1;
    drain();
    pulse_clear();
    chk("ovf_cleared", 32'(fifo_overflow), 32'd0);

    // Early and late end-of-line detection
    overlay_mode = 2'd0;
    send(24'h000020, 1'b1, 1'b0, 1'b1);
    send(24'h000021, 1'b0, 1'b0, 1'b1);
    send(24'h000022, 1'b0, 1'b1, 1'b1);
    chk("eol_early_set", 32'(err_eol_early), 32'd1);
    chk("eol_late_clear", 32'(err_eol_late), 32'd0);
    for (int i = 0; i < 4; i++) send({16'h0000, 8'(8'h23 + i)}, 1'b0, 1'b0, 1'b1);
    chk("eol_late_set", 32'(err_eol_late), 32'd1);
    send(24'h000027, 1'b0, 1'b1, 1'b1);
    idle(1);
    chk("f3_pulses", 32'(pulses), 32'd3);
    chk("f3_counts", {12'd0, frame_mask_cnt[9:0], frame_sat_cnt[9:0]}, 32'd0);
    pulse_clear();
    chk("errs_cleared", {29'd0, err_eol_early, err_eol_late, fifo_overflow}, 32'd0);
    drain();

    // Restart mid-frame: aborted counts never reach the outputs
    for (int i = 0; i < 5; i++) send({16'h00FF, 8'(8'h30 + i)}, i == 0, 1'b0, 1'b1);
    chk("abort_late", 32'(err_eol_late), 32'd1);
    clear_errors = 1'b1;
    send(24'hFF0040, 1'b1, 1'b0, 1'b1);
    clear_errors = 1'b0;
    chk("sof_set_wins", 32'(err_sof), 32'd1);
    chk("sof_late_cleared", 32'(err_eol_late), 32'd0);
    chk("abort_mask_cnt", 32'(frame_mask_cnt), 32'd0);
    for (int i = 1; i < 8; i++) begin
      send({(i == 6) ? 8'h01 : 8'h00, (i == 3) ? 8'hFF : 8'h00, 8'(8'h40 + i)},
           1'b0, (i == 3) || (i == 7), 1'b1);
    end
    idle(1);
    chk("f4_mask_cnt", 32'(frame_mask_cnt), 32'd1);
    chk("f4_sat_cnt", 32'(frame_sat_cnt), 32'd2);
    chk("f4_pulses", 32'(pulses), 32'd4);
    drain();

    // Reset in the middle of a frame with data buffered
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) send({16'h0000, 8'(8'h50 + i)}, i == 0, 1'b0, 1'b0);
    idle(1);
    chk("pre_rst_valid", 32'(m_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_tready", 32'(s_tready), 32'd0);
    chk("mrst_mout", {22'd0, m_tvalid, m_tuser, m_tdata}, 32'd0);
    chk("mrst_counts", 32'(frame_mask_cnt | frame_sat_cnt), 32'd0);
    chk("mrst_flags", {27'd0, frame_stats_valid, err_sof, err_eol_early, err_eol_late,
                       fifo_overflow}, 32'd0);
    idle(2);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_empty", 32'(m_tvalid), 32'd0);
    chk("post_rst_tready", 32'(s_tready), 32'd1);
    m_tready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
